// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer
// Streams the 3x3 result matrix (N_ELEM elements of ELEM_W bits) out as bytes over a
// valid/ready handshake. Order: C[0]..C[N_ELEM-1], each element LSB byte first; the top
// byte of an element is zero-extended.
// Optional build macro: SERIAL_CHECKSUM_EN appends one XOR checksum byte after the data.
// Every output comes straight from a flop; the FSM lives in one always_ff.

module matrix_result_serializer #(
    parameter int unsigned N_ELEM         = 9,
    parameter int unsigned ELEM_W         = 18,
    // Must satisfy 8*BYTES_PER_ELEM >= ELEM_W.
    parameter int unsigned BYTES_PER_ELEM = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_ELEM*ELEM_W-1:0]   c_flat,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned EW  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned BW  = (BYTES_PER_ELEM > 1) ? $clog2(BYTES_PER_ELEM) : 1;
    localparam int unsigned PW  = 8 * BYTES_PER_ELEM;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StFin
    } state_e;

    state_e                      r_state;
    logic [N_ELEM*ELEM_W-1:0]    r_shadow;
    logic [EW-1:0]               r_elem_idx;
    logic [BW-1:0]               r_byte_idx;
    logic [7:0]                  r_out_data;
    logic                        r_out_valid;
    logic                        r_busy;
    logic                        r_done;
`ifdef SERIAL_CHECKSUM_EN
    logic [7:0]                  r_csum;
    // Set once the last data byte has gone; the byte on the bus is then the checksum.
    logic                        r_in_csum;
`endif

    logic                        w_last_byte;
    logic                        w_last_data;
    logic [EW-1:0]               w_nxt_elem_idx;
    logic [BW-1:0]               w_nxt_byte_idx;
    logic [ELEM_W-1:0]           w_sel_elem;
    logic [PW-1:0]               w_sel_padded;
    logic [7:0]                  w_sel_byte;
    logic [PW-1:0]               w_first_padded;
    logic [7:0]                  w_first_byte;

    // Index advance: byte index wraps per element, element index steps on the wrap.
    always_comb begin
        w_last_byte = (r_byte_idx == BW'(BYTES_PER_ELEM - 1));
        w_last_data = w_last_byte && (r_elem_idx == EW'(N_ELEM - 1));
        if (w_last_byte) begin
            w_nxt_byte_idx = '0;
            w_nxt_elem_idx = r_elem_idx + EW'(1);
        end else begin
            w_nxt_byte_idx = r_byte_idx + BW'(1);
            w_nxt_elem_idx = r_elem_idx;
        end
    end

    // Select the byte that goes on the bus after the current transfer.
    always_comb begin
        w_sel_elem = '0;
        for (int unsigned i = 0; i < N_ELEM; i++) begin
            if (w_nxt_elem_idx == EW'(i)) begin
                w_sel_elem = r_shadow[i*ELEM_W +: ELEM_W];
            end
        end
        w_sel_padded               = '0;
        w_sel_padded[ELEM_W-1:0]   = w_sel_elem;
        w_sel_byte = '0;
        for (int unsigned j = 0; j < BYTES_PER_ELEM; j++) begin
            if (w_nxt_byte_idx == BW'(j)) begin
                w_sel_byte = w_sel_padded[j*8 +: 8];
            end
        end
    end

    // First byte is taken from c_flat directly so it is on the bus right after LOAD.
    always_comb begin
        w_first_padded             = '0;
        w_first_padded[ELEM_W-1:0] = c_flat[ELEM_W-1:0];
        w_first_byte               = w_first_padded[7:0];
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_shadow    <= '0;
            r_elem_idx  <= '0;
            r_byte_idx  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef SERIAL_CHECKSUM_EN
            r_csum      <= '0;
            r_in_csum   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_out_data  <= '0;
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                    if (enable) begin
                        r_state <= StLoad;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end

                StLoad: begin
                    if (!enable) begin
                        r_state     <= StIdle;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                    end else begin
                        r_shadow    <= c_flat;
                        r_elem_idx  <= '0;
                        r_byte_idx  <= '0;
                        r_out_data  <= w_first_byte;
                        r_out_valid <= 1'b1;
                        r_state     <= StSend;
`ifdef SERIAL_CHECKSUM_EN
                        r_csum      <= '0;
                        r_in_csum   <= 1'b0;
`endif
                    end
                end

                StSend: begin
                    if (!enable) begin
                        // Abort: drop the stream without ever raising done.
                        r_state     <= StIdle;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                    end else if (out_ready) begin
`ifdef SERIAL_CHECKSUM_EN
                        if (r_in_csum) begin
                            r_state     <= StFin;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                        end else if (w_last_data) begin
                            // Final accumulate folded straight into the checksum byte.
                            r_csum      <= r_csum ^ r_out_data;
                            r_out_data  <= r_csum ^ r_out_data;
                            r_in_csum   <= 1'b1;
                        end else begin
                            r_csum      <= r_csum ^ r_out_data;
                            r_elem_idx  <= w_nxt_elem_idx;
                            r_byte_idx  <= w_nxt_byte_idx;
                            r_out_data  <= w_sel_byte;
                        end
`else
                        if (w_last_data) begin
                            r_state     <= StFin;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                        end else begin
                            r_elem_idx  <= w_nxt_elem_idx;
                            r_byte_idx  <= w_nxt_byte_idx;
                            r_out_data  <= w_sel_byte;
                        end
`endif
                    end
                end

                StFin: begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_busy      <= 1'b0;
                    if (!enable) begin
                        r_state <= StIdle;
                        r_done  <= 1'b0;
                    end else begin
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer with a byte scoreboard.
module tb_matrix_result_serializer;

    localparam int unsigned N_ELEM = 9;
    localparam int unsigned ELEM_W = 18;
`ifdef SERIAL_CHECKSUM_EN
    localparam int STREAM_LEN = 28;
`else
    localparam int STREAM_LEN = 27;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      enable;
    logic [N_ELEM*ELEM_W-1:0]  c_flat;
    logic                      out_ready;
    logic [7:0]                out_data;
    logic                      out_valid;
    logic                      busy;
    logic                      done;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    matrix_result_serializer #(
        .N_ELEM         (9),
        .ELEM_W         (18),
        .BYTES_PER_ELEM (3)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .c_flat    (c_flat),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference stream for a given matrix: element-major, LSB first, top byte zero-extended.
    task automatic push_model(input logic [N_ELEM*ELEM_W-1:0] c);
        logic [17:0] e;
        logic [7:0]  x;
        logic [7:0]  b;
        x = 8'h00;
        for (int i = 0; i < 9; i++) begin
            e = c[i*18 +: 18];
            for (int k = 0; k < 3; k++) begin
                if (k == 0)      b = e[7:0];
                else if (k == 1) b = e[15:8];
                else             b = {6'b0, e[17:16]};
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
`ifdef SERIAL_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Literal expectation for the basic matrix (C0=3FFFF, C1=12345).
    task automatic push_basic();
        logic [7:0] lit [6];
        lit[0] = 8'hFF; lit[1] = 8'hFF; lit[2] = 8'h03;
        lit[3] = 8'h45; lit[4] = 8'h23; lit[5] = 8'h01;
        for (int i = 0; i < 6; i++) exp_q.push_back(lit[i]);
        for (int i = 6; i < 27; i++) exp_q.push_back(8'h00);
`ifdef SERIAL_CHECKSUM_EN
        exp_q.push_back(8'h64);
`endif
    endtask

    // Raise enable from IDLE and consume the stream. stop_after<0 runs to done.
    task automatic run(input bit bp, input int stop_after, input bit isolate,
                       input bit timing);
        logic [7:0] pat [6];
        logic [7:0] held;
        logic [7:0] eb;
        bit         hold_pend;
        int         e, xf, vcyc, first, pidx;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
        hold_pend = 0; held = 8'h00;
        e = 0; xf = 0; vcyc = 0; first = -1; pidx = 0;
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        check("load_busy", {31'b0, busy}, 32'd1);
        check("load_valid", {31'b0, out_valid}, 32'd0);
        while (e < 200) begin
            if (isolate && e >= 1) c_flat = '1;
            if (stop_after >= 0 && xf == stop_after) break;
            out_ready = bp ? pat[pidx % 6][0] : 1'b1;
            pidx++;
            if (hold_pend) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_data", {24'b0, out_data}, {24'b0, held});
                hold_pend = 0;
            end
            if (out_valid) begin
                vcyc++;
                if (first < 0) first = e;
                if (out_ready) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $error("FAIL extra_byte observed=%0h expected=none", out_data);
                    end else begin
                        eb = exp_q.pop_front();
                        check("byte", {24'b0, out_data}, {24'b0, eb});
                    end
                    xf++;
                end else begin
                    hold_pend = 1;
                    held      = out_data;
                end
            end
            tick();
            e++;
            if (done) break;
        end
        if (stop_after < 0) begin
            check("xfers", xf, STREAM_LEN);
            check("done", {31'b0, done}, 32'd1);
            check("fin_valid", {31'b0, out_valid}, 32'd0);
            check("queue_empty", exp_q.size(), 32'd0);
            if (timing) begin
                check("first_valid_edge", first, 32'd1);
                check("valid_cycles", vcyc, STREAM_LEN);
                check("done_edge", e, STREAM_LEN + 1);
            end
        end
    endtask

    task automatic set_basic();
        c_flat = '0;
        c_flat[0 +: 18]  = 18'h3FFFF;
        c_flat[18 +: 18] = 18'h12345;
    endtask

    task automatic set_pattern();
        for (int i = 0; i < 9; i++) c_flat[i*18 +: 18] = 18'(i * 32'h4321 + 32'h1357);
    endtask

    task automatic leave_fin();
        enable = 1'b0;
        tick();
        check("idle_done", {31'b0, done}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; out_ready = 1'b0; c_flat = '0;
        tick(); tick(); tick();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", {24'b0, out_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic stream with timing, then FIN holds while enable stays high.
        set_basic(); push_basic();
        run(0, -1, 0, 1);
        tick();
        check("fin_hold", {31'b0, done}, 32'd1);
        leave_fin();

        // Back-pressure.
        set_basic(); push_basic();
        run(1, -1, 0, 0);
        leave_fin();

        // Input isolation: c_flat goes all-ones after LOAD.
        set_pattern(); push_model(c_flat);
        run(0, -1, 1, 0);
        leave_fin();

        // Abort after 5 transfers, then a fresh full stream.
        set_pattern(); push_model(c_flat);
        run(0, 5, 0, 0);
        enable = 1'b0;
        tick();
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_data", {24'b0, out_data}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        tick(); tick();
        check("abort_done", {31'b0, done}, 32'd0);
        exp_q.delete();
        push_model(c_flat);
        run(0, -1, 0, 1);
        leave_fin();

        // Reset at element 4 byte 1, then restart from C[0] byte 0.
        set_pattern(); push_model(c_flat);
        run(0, 13, 0, 0);
        check("pre_rst_byte", {24'b0, out_data}, {24'b0, exp_q[0]});
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_data", {24'b0, out_data}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        push_model(c_flat);
        run(0, -1, 0, 1);
        leave_fin();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
- Downstream stage of the matrix multiply core. Takes the 3x3 result matrix (nine 18-bit sums) and streams it out as bytes over a valid/ready handshake.
- Byte order: element-major, C[0] to C[8]; within each element, LSB-first.
- Sits between the compute stage and the chip output pins (uo_out, uio_out[0]). Driven by the top-level FSM enable and reports `done` back to it.

Parameters:
- N_ELEM, 9, number of result elements.
- ELEM_W, 18, width of each result element.
- BYTES_PER_ELEM, 3, bytes per element; must satisfy 8*BYTES_PER_ELEM >= ELEM_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  level; high while the top FSM is in its output state.
- c_flat  input  N_ELEM*ELEM_W  result bus; element i is at bits [i*ELEM_W +: ELEM_W].
- out_ready  input  1  consumer accepts a byte this cycle.
- out_data  output  8  current byte; 0 when out_valid=0.
- out_valid  output  1  out_data is valid.
- busy  output  1  high in states LOAD and SEND.
- done  output  1  high in state FIN.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Reset is the `reset` input; the clock is `clk`.
- On reset, all of the following clear to 0: state=IDLE, out_data, out_valid, busy, done, the shadow register, byte index, element index.
- Reset asserted mid-stream aborts the transfer in the same edge. No further bytes are emitted.
- States: IDLE, LOAD, SEND, FIN.
- IDLE:
  - When enable=1, go to LOAD.
  - All outputs 0.
- LOAD (one cycle):
  - Copy c_flat into the internal shadow register.
  - Clear elem_idx=0 and byte_idx=0.
  - Go to SEND.
  - c_flat is not sampled again after this cycle.
- SEND:
  - out_valid=1.
  - out_data = byte byte_idx of shadow element elem_idx.
  - Byte 2 is zero-extended: bits [17:16] of the element, upper 6 bits 0.
  - A transfer occurs on any edge where out_valid and out_ready are both 1.
  - On a transfer: byte_idx increments; at byte_idx=BYTES_PER_ELEM-1 it wraps to 0 and elem_idx increments.
  - The transfer of elem_idx=N_ELEM-1, byte_idx=BYTES_PER_ELEM-1 moves to FIN. out_valid drops on that same edge.
  - When out_ready=0: out_data and out_valid hold stable and the indices do not move. Back-pressure may last any number of cycles.
- FIN:
  - done=1, out_valid=0.
  - Stay in FIN while enable=1.
  - When enable=0, return to IDLE.
- enable=0 in LOAD or SEND aborts the stream:
  - Go to IDLE on the next edge; out_valid=0 from that edge.
  - done is never asserted for an aborted stream.
- Latency and throughput:
  - enable rises at edge t, so the state is LOAD after t.
  - First out_valid is after edge t+1.
  - With out_ready held at 1, one byte is sent per cycle: 27 bytes in 27 cycles.
  - done is high after edge t+28.
- Outputs are registered: out_data, out_valid, done and busy come straight from flops.

Optional Feature:
- Macro: SERIAL_CHECKSUM_EN.
- Defined:
  - After the last data byte, SEND emits one extra byte: the XOR of all 27 data bytes, accumulated in a register on each transfer and cleared in LOAD.
  - The stream is 28 bytes long; FIN is entered after the checksum transfer.
  - The checksum byte follows the same handshake and back-pressure rules as data bytes.
- Not defined:
  - The stream is 27 bytes. No accumulator register exists in the netlist.

Test Plan:
- Reset check:
  - Stimulus: assert reset mid-SEND, at elem 4 byte 1, with out_ready=1.
  - Required: next edge has out_valid=0, done=0, busy=0, state IDLE.
  - Required: after release, enable high restarts the stream from C[0] byte 0.
- Basic stream:
  - Stimulus: C[0]=0x3FFFF, C[1]=0x12345, all others 0; out_ready=1; raise enable.
  - Required byte sequence: FF FF 03 45 23 01, then 21 bytes of 00.
  - Required: out_valid high for exactly 27 consecutive cycles starting 2 edges after enable rises; done high 28 edges after enable rises.
- Back-pressure:
  - Stimulus: same data; out_ready toggles 1,0,0,1,0,1…
  - Required: identical byte sequence; out_data stable through every out_ready=0 cycle; exactly 27 transfers.
- Input isolation:
  - Stimulus: change c_flat to all-ones after the LOAD cycle.
  - Required: the stream still carries the values captured in LOAD.
- Abort:
  - Stimulus: drop enable after 5 transfers.
  - Required: out_valid=0 on the next edge; done stays 0.
  - Required: re-raising enable produces a fresh 27-byte stream.
- Checksum (SERIAL_CHECKSUM_EN defined):
  - Stimulus: basic-stream data.
  - Required: byte 28 = FF^FF^03^45^23^01 = 0x64; done only after the 28th transfer.
